gnss_sample_packer: RTL and testbench

Parametrised successor to the board-level GNSS front-end capture. It samples I/Q ADC bits and the external GNSS sample clock in the system clock domain, packs consecutive samples into fixed-width words, and buffers them in a first-word-fall-through (FWFT) FIFO with valid/ready output. It sits between the FPGA header pins and the correlator/DMA path, and reports overflow status for LEDs and debug.

---
 rtl/gnss_sample_packer.sv | 164 ++++++++++++++++
 tb/tb_gnss_sample_packer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gnss_sample_packer.sv
// GNSS front-end capture: synchronises the external sample clock and I/Q bits into the system
// clock domain, packs samples into words and buffers them in a first-word-fall-through FIFO.
module gnss_sample_packer #(
   parameter int unsigned SAMPLE_BITS = 2,
   parameter int unsigned IQ_MODE     = 1,
   parameter int unsigned WORD_BITS   = 32,
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                   i_clk,
   input  logic                   i_nrst,
   input  logic                   i_gnssclk,
   input  logic [SAMPLE_BITS-1:0] i_sample_i,
   input  logic [SAMPLE_BITS-1:0] i_sample_q,
   input  logic                   i_enable,
   output logic                   o_out_valid,
   input  logic                   i_out_ready,
   output logic [WORD_BITS-1:0]   o_out_data,
   output logic                   o_overflow,
   output logic [15:0]            o_drop_count,
   input  logic                   i_clr_overflow
);

   localparam int unsigned G     = SAMPLE_BITS * ((IQ_MODE != 0) ? 2 : 1);
   localparam int unsigned SPW   = WORD_BITS / G;
   localparam int unsigned IDX_W = (SPW > 1) ? $clog2(SPW) : 1;
   localparam int unsigned AW    = $clog2(FIFO_DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SPW - 1);

   // Synchronisers: clock and data take the same number of stages so they stay aligned.
   logic [SYNC_STAGES-1:0]                  r_gclk_sync;
   logic                                    r_gclk_prev;
   logic [SYNC_STAGES-1:0][SAMPLE_BITS-1:0] r_si_sync;
   logic [G-1:0]                            w_group;
   logic                                    w_strobe;

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         r_gclk_sync <= '0;
         r_gclk_prev <= 1'b0;
         r_si_sync   <= '0;
      end else begin
         r_gclk_sync <= {r_gclk_sync[SYNC_STAGES-2:0], i_gnssclk};
         r_gclk_prev <= r_gclk_sync[SYNC_STAGES-1];
         r_si_sync   <= {r_si_sync[SYNC_STAGES-2:0], i_sample_i};
      end
   end

   if (IQ_MODE != 0) begin : g_iq
      logic [SYNC_STAGES-1:0][SAMPLE_BITS-1:0] r_sq_sync;

      always_ff @(posedge i_clk or negedge i_nrst) begin
         if (!i_nrst) begin
            r_sq_sync <= '0;
         end else begin
            r_sq_sync <= {r_sq_sync[SYNC_STAGES-2:0], i_sample_q};
         end
      end

      assign w_group = {r_sq_sync[SYNC_STAGES-1], r_si_sync[SYNC_STAGES-1]};
   end else begin : g_i_only
      logic w_unused_q;
      assign w_unused_q = ^i_sample_q;
      assign w_group    = r_si_sync[SYNC_STAGES-1];
   end

   assign w_strobe = r_gclk_sync[SYNC_STAGES-1] & ~r_gclk_prev;

   // Packer: first sample lands in the LSBs; a completed word is handed to the FIFO next cycle.
   logic [IDX_W-1:0]     r_idx;
   logic [WORD_BITS-1:0] r_word;
   logic [WORD_BITS-1:0] w_word_next;
   logic                 r_push;
   logic [WORD_BITS-1:0] r_push_data;

   assign w_word_next = r_word | (WORD_BITS'(w_group) << (G * r_idx));

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         r_idx       <= '0;
         r_word      <= '0;
         r_push      <= 1'b0;
         r_push_data <= '0;
      end else begin
         r_push <= 1'b0;
         if (!i_enable) begin
            r_idx  <= '0;
            r_word <= '0;
         end else if (w_strobe) begin
            if (r_idx == LAST_IDX) begin
               r_idx       <= '0;
               r_word      <= '0;
               r_push      <= 1'b1;
               r_push_data <= w_word_next;
            end else begin
               r_idx  <= r_idx + IDX_W'(1);
               r_word <= w_word_next;
            end
         end
      end
   end

   // FWFT FIFO: pointer MSB separates full from empty.
   logic [WORD_BITS-1:0] r_mem [FIFO_DEPTH];
   logic [AW:0]          r_wr_ptr;
   logic [AW:0]          r_rd_ptr;
   logic                 w_empty;
   logic                 w_full;
   logic                 w_pop;
   logic                 w_wr_en;
   logic                 w_drop;

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_out_valid = ~w_empty;
   assign w_pop   = o_out_valid & i_out_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_wr_en = r_push & (~w_full | w_pop);
   assign w_drop  = r_push & w_full & ~w_pop;
   assign o_out_data = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge i_clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr[AW-1:0]] <= r_push_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
         end
      end
   end

   logic        r_overflow;
   logic [15:0] r_drop_count;

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         r_overflow   <= 1'b0;
         r_drop_count <= '0;
      end else if (i_clr_overflow) begin
         r_overflow   <= w_drop;
         r_drop_count <= {15'd0, w_drop};
      end else if (w_drop) begin
         r_overflow <= 1'b1;
         if (r_drop_count != 16'hFFFF) begin
            r_drop_count <= r_drop_count + 16'd1;
         end
      end
   end

   assign o_overflow   = r_overflow;
   assign o_drop_count = r_drop_count;

endmodule

// File: tb/tb_gnss_sample_packer.sv
// Randomised bench for gnss_sample_packer: a queue-based word model predicts every popped word
// and the overflow/drop status; a second instance covers the I-only 1-bit configuration.
module tb_gnss_sample_packer;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned SPW   = 8;

   logic        clk = 1'b0;
   logic        nrst;
   logic        gnssclk;
   logic [1:0]  s_i;
   logic [1:0]  s_q;
   logic        enable;
   logic        valid;
   logic        ready;
   logic [31:0] data;
   logic        ovf;
   logic [15:0] drops;
   logic        clr;

   logic        g2clk;
   logic        s2i;
   logic        en2;
   logic        valid2;
   logic        ready2;
   logic [7:0]  data2;
   logic        ovf2;
   logic [15:0] drops2;

   always #5 clk = ~clk;

   gnss_sample_packer u_dut (
      .i_clk          (clk),
      .i_nrst         (nrst),
      .i_gnssclk      (gnssclk),
      .i_sample_i     (s_i),
      .i_sample_q     (s_q),
      .i_enable       (enable),
      .o_out_valid    (valid),
      .i_out_ready    (ready),
      .o_out_data     (data),
      .o_overflow     (ovf),
      .o_drop_count   (drops),
      .i_clr_overflow (clr)
   );

   gnss_sample_packer #(
      .SAMPLE_BITS (1),
      .IQ_MODE     (0),
      .WORD_BITS   (8)
   ) u_dut_i1 (
      .i_clk          (clk),
      .i_nrst         (nrst),
      .i_gnssclk      (g2clk),
      .i_sample_i     (s2i),
      .i_sample_q     (1'b0),
      .i_enable       (en2),
      .o_out_valid    (valid2),
      .i_out_ready    (ready2),
      .o_out_data     (data2),
      .o_overflow     (ovf2),
      .o_drop_count   (drops2),
      .i_clr_overflow (1'b0)
   );

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Reference model: a list of captured groups and a bounded queue of stored words.
   logic [3:0]  m_grp[$];
   logic [31:0] m_q[$];
   bit          m_en;
   bit          m_ovf;
   int unsigned m_drops;

   task automatic model_sample(input logic [1:0] si, input logic [1:0] sq);
      logic [31:0] w;
      if (!m_en) return;
      m_grp.push_back({sq, si});
      if (m_grp.size() == SPW) begin
         w = 0;
         for (int k = 0; k < SPW; k++) w = w + (32'(m_grp[k]) << (4 * k));
         m_grp.delete();
         if (m_q.size() == DEPTH) begin
            m_ovf = 1'b1;
            if (m_drops < 65535) m_drops++;
         end else begin
            m_q.push_back(w);
         end
      end
   endtask

   task automatic model_reset();
      m_grp.delete();
      m_q.delete();
      m_ovf   = 1'b0;
      m_drops = 0;
   endtask

   logic [31:0] last_pop;
   int unsigned n_pops = 0;

   // Head of the FIFO must always match the model's oldest word, held or popped.
   always @(negedge clk) begin
      if (nrst && valid) begin
         if (m_q.size() == 0) begin
            check_eq("spurious_word", 32'(valid), 32'd0);
         end else begin
            check_eq("head_word", data, m_q[0]);
            if (ready) begin
               last_pop = m_q.pop_front();
               n_pops++;
            end
         end
      end
   end

   task automatic pin_rise(input logic [1:0] si, input logic [1:0] sq);
      s_i = si;
      s_q = sq;
      #(10 * $urandom_range(3, 5));
      gnssclk = 1'b1;
      if (nrst) model_sample(si, sq);
   endtask

   task automatic pin_sample(input logic [1:0] si, input logic [1:0] sq);
      pin_rise(si, sq);
      #(10 * $urandom_range(3, 5));
      gnssclk = 1'b0;
   endtask

   task automatic send_word(input bit clr_on_drop);
      for (int k = 0; k < SPW - 1; k++) pin_sample(2'($urandom), 2'($urandom));
      if (clr_on_drop) begin
         m_ovf   = 1'b0;
         m_drops = 0;
      end
      pin_rise(2'($urandom), 2'($urandom));
      if (clr_on_drop) begin
         repeat (3) @(posedge clk);
         #2 clr = 1'b1;
         @(posedge clk);
         #2 clr = 1'b0;
      end else begin
         #40;
      end
      gnssclk = 1'b0;
   endtask

   task automatic idle(input int unsigned n);
      #(10 * n);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not finish, %0d checks so far", n_checks);
      $fatal(1);
   end

   initial begin
      int unsigned p0;
      int unsigned lat;
      int pat[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
      logic [7:0] exp6;

      nrst = 1'b0; gnssclk = 1'b0; s_i = '0; s_q = '0; enable = 1'b1; ready = 1'b1; clr = 1'b0;
      g2clk = 1'b0; s2i = 1'b0; en2 = 1'b1; ready2 = 1'b0;
      m_en = 1'b1;
      model_reset();
      @(posedge clk);
      #2;

      // Reset held while the pin clock toggles: nothing may come out.
      for (int k = 0; k < 3; k++) begin
         pin_sample(2'($urandom), 2'($urandom));
         check_eq("rst_valid", 32'(valid), 32'd0);
         check_eq("rst_data", data, 32'd0);
         check_eq("rst_ovf", 32'(ovf), 32'd0);
         check_eq("rst_drops", 32'(drops), 32'd0);
      end
      nrst = 1'b1;
      idle(3);

      // Seven edges produce no word; the eighth completes 0x369C369C within 5 cycles.
      for (int k = 0; k < 7; k++) pin_sample(2'(k), ~2'(k));
      idle(6);
      check_eq("no_early_word", 32'(valid), 32'd0);
      pin_rise(2'(7), ~2'(7));
      lat = 0;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk);
         #2;
         if (valid && lat == 0) lat = c;
      end
      check_eq("first_word_latency_ok", 32'(lat >= 1 && lat <= 5), 32'd1);
      gnssclk = 1'b0;
      idle(6);
      check_eq("first_word_count", n_pops, 32'd1);
      check_eq("first_word_value", last_pop, 32'h369C369C);

      // Overfill with ready low: sixteen stored, one dropped, then drained in order.
      ready = 1'b0;
      for (int w = 0; w < 17; w++) send_word(1'b0);
      idle(6);
      check_eq("fill_ovf", 32'(ovf), 32'(m_ovf));
      check_eq("fill_drops", 32'(drops), m_drops);
      check_eq("fill_ovf_set", 32'(ovf), 32'd1);
      p0 = n_pops;
      ready = 1'b1;
      idle(25);
      check_eq("drain_count", n_pops - p0, 32'd16);
      check_eq("drain_empty", 32'(valid), 32'd0);

      clr = 1'b1;
      idle(1);
      clr = 1'b0;
      m_ovf = 1'b0;
      m_drops = 0;
      idle(1);
      check_eq("clr_ovf", 32'(ovf), 32'd0);
      check_eq("clr_drops", 32'(drops), 32'd0);

      // Enable drop mid-word discards the partial word.
      for (int k = 0; k < 5; k++) pin_sample(2'($urandom), 2'($urandom));
      idle(2);
      enable = 1'b0;
      m_en = 1'b0;
      m_grp.delete();
      idle(3);
      enable = 1'b1;
      m_en = 1'b1;
      p0 = n_pops;
      for (int k = 0; k < 8; k++) pin_sample(2'd1, 2'd2);
      idle(6);
      check_eq("enable_word_count", n_pops - p0, 32'd1);
      check_eq("enable_word_value", last_pop, 32'h99999999);

      // A continuously ready consumer never overflows.
      p0 = n_pops;
      for (int w = 0; w < 3; w++) send_word(1'b0);
      idle(6);
      check_eq("stream_count", n_pops - p0, 32'd3);
      check_eq("stream_ovf", 32'(ovf), 32'd0);
      check_eq("stream_drops", 32'(drops), 32'd0);

      // Clear coinciding with a drop leaves exactly one drop recorded.
      ready = 1'b0;
      for (int w = 0; w < 17; w++) send_word(1'b0);
      idle(6);
      check_eq("drop1_drops", 32'(drops), m_drops);
      send_word(1'b1);
      idle(6);
      check_eq("clr_drop_ovf", 32'(ovf), 32'(m_ovf));
      check_eq("clr_drop_drops", 32'(drops), m_drops);
      check_eq("clr_drop_one", 32'(drops), 32'd1);
      send_word(1'b0);
      idle(6);
      check_eq("drop_after_clr", 32'(drops), m_drops);
      p0 = n_pops;
      ready = 1'b1;
      idle(25);
      check_eq("drain2_count", n_pops - p0, 32'd16);
      check_eq("drain2_empty", 32'(valid), 32'd0);

      // Reset mid-word discards the partial word and all status.
      for (int k = 0; k < 3; k++) pin_sample(2'($urandom), 2'($urandom));
      nrst = 1'b0;
      model_reset();
      idle(2);
      check_eq("midrst_valid", 32'(valid), 32'd0);
      check_eq("midrst_drops", 32'(drops), 32'd0);
      check_eq("midrst_ovf", 32'(ovf), 32'd0);
      nrst = 1'b1;
      idle(2);
      p0 = n_pops;
      send_word(1'b0);
      idle(6);
      check_eq("midrst_word_count", n_pops - p0, 32'd1);

      // I-only, 1-bit samples into 8-bit words.
      exp6 = '0;
      for (int k = 0; k < 8; k++) exp6 = exp6 + 8'(pat[k] << k);
      for (int k = 0; k < 8; k++) begin
         s2i = pat[k][0];
         #(10 * $urandom_range(3, 5));
         g2clk = 1'b1;
         #(10 * $urandom_range(3, 5));
         g2clk = 1'b0;
      end
      lat = 0;
      for (int c = 0; c < 10 && !valid2; c++) begin
         @(posedge clk);
         #2;
      end
      check_eq("i1_valid", 32'(valid2), 32'd1);
      check_eq("i1_word", 32'(data2), 32'(exp6));
      check_eq("i1_word_const", 32'(data2), 32'h4D);
      check_eq("i1_ovf", 32'(ovf2), 32'd0);
      ready2 = 1'b1;
      idle(1);
      ready2 = 1'b0;
      check_eq("i1_drained", 32'(valid2), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
